// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - control/strobe bundle between game_ctrl and its environment
// Purpose: groups the pin-level inputs (sw7, debounced buttons, answer switches),
//   the submodule feedback (rand_num, beep_over) and every strobe/status output
//   of the game sequencer.
// Modports:
//   master - used by game_ctrl: takes start/next/sure/sw/rand_num/beep_over,
//            drives rand_st/cst/dzst/dz_num/bst/beep_mode/dst/disp_num/
//            target/time_left/err_cnt/state_o
//   slave  - used by the surrounding top level (or a bench): the reverse.
interface game_ctrl_if;
  logic       start;
  logic       next;
  logic       sure;
  logic [6:0] sw;
  logic [6:0] rand_num;
  logic       beep_over;
  logic       rand_st;
  logic       cst;
  logic       dzst;
  logic [2:0] dz_num;
  logic       bst;
  logic       beep_mode;
  logic       dst;
  logic [1:0] disp_num;
  logic [6:0] target;
  logic [5:0] time_left;
  logic [2:0] err_cnt;
  logic [3:0] state_o;

  modport master (
    input  start, next, sure, sw, rand_num, beep_over,
    output rand_st, cst, dzst, dz_num, bst, beep_mode, dst, disp_num,
           target, time_left, err_cnt, state_o
  );

  modport slave (
    output start, next, sure, sw, rand_num, beep_over,
    input  rand_st, cst, dzst, dz_num, bst, beep_mode, dst, disp_num,
           target, time_left, err_cnt, state_o
  );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - central sequencer of the three-round number-guessing game
// Purpose: game state machine (idle, greet, target fetch, play, check, beep
//   feedback, win, lose) plus round/target/timer/error bookkeeping. Drives only
//   the start/enable strobes of the random generator, matrix/counter, beeper
//   and segment display.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   gif  - game_ctrl_if.master: start (sw7 level), next (btn7), sure (btn0),
//          sw[6:0] answer, rand_num, beep_over in; rand_st, cst, dzst, dz_num,
//          bst, beep_mode, dst, disp_num, target, time_left, err_cnt, state_o out
module game_ctrl #(
  parameter int TICK_DIV   = 1000000,
  parameter int ROUND_TIME = 30,
  parameter int MAX_ERR    = 3
) (
  input  logic         clk,
  input  logic         rst,
  game_ctrl_if.master  gif
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [5:0]       RT       = 6'(ROUND_TIME);
  localparam logic [2:0]       ERR_LIM  = 3'(MAX_ERR);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    GREET = 4'd1,
    REQ   = 4'd2,
    LATCH = 4'd3,
    PLAY  = 4'd4,
    CHECK = 4'd5,
    BOK   = 4'd6,
    BERR  = 4'd7,
    WIN   = 4'd8,
    LOSE  = 4'd9
  } state_t;

  state_t           state, state_nx;
  logic             next_q, sure_q;
  logic [DIV_W-1:0] div;
  logic [1:0]       round;
  logic [6:0]       target;
  logic [5:0]       time_left;
  logic [2:0]       err_cnt;
  logic             rand_st, bst, beep_mode;

  logic next_rise, sure_rise, tick, correct;

  assign next_rise = gif.next & ~next_q;
  assign sure_rise = gif.sure & ~sure_q;
  assign tick      = (state == PLAY) && (div == DIV_LAST);
  assign correct   = (gif.sw == target);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; start=0 overrides everything
  always_comb begin
    state_nx = state;
    if (!gif.start) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  state_nx = GREET;
        GREET: if (next_rise) state_nx = REQ;
        REQ:   state_nx = LATCH;
        LATCH: state_nx = PLAY;
        // Final tick beats a simultaneous answer submission
        PLAY: begin
          if (tick && time_left == 6'd1) state_nx = LOSE;
          else if (sure_rise)            state_nx = CHECK;
        end
        CHECK: state_nx = correct ? BOK : BERR;
        BOK:   if (gif.beep_over) state_nx = (round == 2'd2) ? WIN : REQ;
        BERR:  if (gif.beep_over) state_nx = (err_cnt == ERR_LIM) ? LOSE : PLAY;
        WIN, LOSE: if (next_rise) state_nx = GREET;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Level outputs decoded from the current state
  always_comb begin
    gif.cst    = 1'b0;
    gif.dzst   = 1'b0;
    gif.dz_num = 3'd0;
    gif.dst    = 1'b0;
    case (state)
      GREET: begin
        gif.dzst = 1'b1;
        gif.dst  = 1'b1;
      end
      PLAY: begin
        gif.cst    = 1'b1;
        gif.dzst   = 1'b1;
        gif.dz_num = {1'b0, round} + 3'd1;
        gif.dst    = 1'b1;
      end
      WIN: begin
        gif.dzst   = 1'b1;
        gif.dz_num = 3'd4;
        gif.dst    = 1'b1;
      end
      LOSE: begin
        gif.dzst   = 1'b1;
        gif.dz_num = 3'd5;
        gif.dst    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: edge history, registered strobes, round/target/timer/errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_q    <= 1'b0;
      sure_q    <= 1'b0;
      rand_st   <= 1'b0;
      bst       <= 1'b0;
      beep_mode <= 1'b0;
      div       <= '0;
      round     <= 2'd0;
      target    <= 7'd0;
      time_left <= RT;
      err_cnt   <= 3'd0;
    end else begin
      next_q  <= gif.next;
      sure_q  <= gif.sure;
      // rand_st is high exactly while the FSM sits in REQ
      rand_st <= (state_nx == REQ);
      // Beep strobe fires in the first cycle of BOK/BERR, tone chosen with it
      bst     <= (state == CHECK) && gif.start;
      if (state == CHECK) beep_mode <= ~correct;

      if (!gif.start) begin
        div       <= '0;
        round     <= 2'd0;
        target    <= 7'd0;
        time_left <= RT;
        err_cnt   <= 3'd0;
      end else begin
        case (state)
          GREET: if (next_rise) round <= 2'd0;
          LATCH: begin
            target    <= gif.rand_num;
            time_left <= RT;
            err_cnt   <= 3'd0;
            div       <= '0;
          end
          PLAY: begin
            if (tick) begin
              div       <= '0;
              time_left <= time_left - 6'd1;
            end else begin
              div <= div + DIV_W'(1);
            end
          end
          CHECK: if (!correct) err_cnt <= err_cnt + 3'd1;
          BOK:   if (gif.beep_over && round != 2'd2) round <= round + 2'd1;
          default: ;
        endcase
      end
    end
  end

  assign gif.rand_st   = rand_st;
  assign gif.bst       = bst;
  assign gif.beep_mode = beep_mode;
  assign gif.disp_num  = round;
  assign gif.target    = target;
  assign gif.time_left = time_left;
  assign gif.err_cnt   = err_cnt;
  assign gif.state_o   = state;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  game_ctrl_if gif();

  game_ctrl #(.TICK_DIV(4), .ROUND_TIME(3), .MAX_ERR(2)) dut (
    .clk (clk),
    .rst (rst_n),
    .gif (gif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("check %s miscompared", tag);
    end
  endtask

  // From GREET: next rise -> REQ -> LATCH -> PLAY
  task automatic greet_to_play();
    gif.next = 1'b1;
    step();
    gif.next = 1'b0;
    step();
    step();
  endtask

  // From WIN/LOSE: next rise -> GREET, then release the button
  task automatic end_to_greet();
    gif.next = 1'b1;
    step();
    gif.next = 1'b0;
    step();
  endtask

  // From REQ: play one round with a correct answer and return the beep
  task automatic round_ok(input int r);
    step();
    step();
    chk($sformatf("r%0d_play_state", r), gif.state_o, 4);
    chk($sformatf("r%0d_dz_num", r), gif.dz_num, r + 1);
    gif.sw   = 7'd42;
    gif.sure = 1'b1;
    step();
    chk($sformatf("r%0d_check_state", r), gif.state_o, 5);
    gif.sure = 1'b0;
    step();
    chk($sformatf("r%0d_bok_bst", r), gif.bst, 1);
    chk($sformatf("r%0d_bok_mode", r), gif.beep_mode, 0);
    step();
    chk($sformatf("r%0d_bst_drop", r), gif.bst, 0);
    gif.beep_over = 1'b1;
    step();
    gif.beep_over = 1'b0;
  endtask

  initial begin
    gif.start     = 1'b0;
    gif.next      = 1'b0;
    gif.sure      = 1'b0;
    gif.sw        = 7'd0;
    gif.rand_num  = 7'd42;
    gif.beep_over = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_state", gif.state_o, 0);
    chk("rst_time_left", gif.time_left, 3);
    chk("rst_strobes", {gif.rand_st, gif.bst, gif.cst, gif.dzst, gif.dst}, 0);
    chk("rst_target", gif.target, 0);
    rst_n = 1'b1;

    // Power on, greet, first round fetch
    gif.start = 1'b1;
    step();
    chk("greet_state", gif.state_o, 1);
    chk("greet_disp", {gif.dzst, gif.dz_num, gif.dst}, 5'b1_000_1);
    gif.next = 1'b1;
    step();
    chk("req_state", gif.state_o, 2);
    chk("req_rand_st", gif.rand_st, 1);
    gif.next = 1'b0;
    step();
    chk("latch_state", gif.state_o, 3);
    chk("latch_rand_st", gif.rand_st, 0);
    step();
    chk("play_target", gif.target, 42);
    chk("play_dz_num", gif.dz_num, 1);
    chk("play_cst", gif.cst, 1);

    // Round 0 correct answer (already in PLAY)
    gif.sw   = 7'd42;
    gif.sure = 1'b1;
    step();
    chk("r0_check_state", gif.state_o, 5);
    gif.sure = 1'b0;
    step();
    chk("r0_bok_bst", gif.bst, 1);
    chk("r0_bok_mode", gif.beep_mode, 0);
    step();
    chk("r0_bst_drop", gif.bst, 0);
    gif.beep_over = 1'b1;
    step();
    gif.beep_over = 1'b0;
    chk("r1_req_state", gif.state_o, 2);
    chk("r1_disp_num", gif.disp_num, 1);
    round_ok(1);
    chk("r2_req_state", gif.state_o, 2);
    chk("r2_disp_num", gif.disp_num, 2);
    round_ok(2);
    chk("win_state", gif.state_o, 8);
    chk("win_dz_num", gif.dz_num, 4);
    chk("win_disp_num", gif.disp_num, 2);

    // Two wrong answers -> LOSE
    end_to_greet();
    chk("win_to_greet", gif.state_o, 1);
    greet_to_play();
    chk("g2_play_state", gif.state_o, 4);
    gif.sw   = 7'd41;
    gif.sure = 1'b1;
    step();
    gif.sure = 1'b0;
    step();
    chk("berr1_state", gif.state_o, 7);
    chk("berr1_bst", gif.bst, 1);
    chk("berr1_mode", gif.beep_mode, 1);
    chk("berr1_err", gif.err_cnt, 1);
    gif.beep_over = 1'b1;
    step();
    gif.beep_over = 1'b0;
    chk("berr1_back_play", gif.state_o, 4);
    gif.sure = 1'b1;
    step();
    gif.sure = 1'b0;
    step();
    chk("berr2_err", gif.err_cnt, 2);
    chk("berr2_mode", gif.beep_mode, 1);
    gif.beep_over = 1'b1;
    step();
    gif.beep_over = 1'b0;
    chk("lose_state", gif.state_o, 9);
    chk("lose_dz_num", gif.dz_num, 5);
    chk("lose_mode_hold", gif.beep_mode, 1);

    // Timeout, with a sure rise on the final tick
    end_to_greet();
    greet_to_play();
    chk("g3_err_clear", gif.err_cnt, 0);
    repeat (3) step();
    chk("tmo_c3", gif.time_left, 3);
    step();
    chk("tmo_c4", gif.time_left, 2);
    repeat (4) step();
    chk("tmo_c8", gif.time_left, 1);
    repeat (3) step();
    chk("tmo_c11_state", gif.state_o, 4);
    gif.sw   = 7'd42;
    gif.sure = 1'b1;
    step();
    chk("tmo_c12_state", gif.state_o, 9);
    chk("tmo_c12_time", gif.time_left, 0);
    chk("tmo_c12_bst", gif.bst, 0);
    gif.sure = 1'b0;
    step();
    chk("tmo_no_bst", gif.bst, 0);

    // Asynchronous reset in PLAY with time_left=2
    end_to_greet();
    greet_to_play();
    repeat (4) step();
    chk("pre_rst_time", gif.time_left, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", gif.state_o, 0);
    chk("async_rst_time", gif.time_left, 3);
    chk("async_rst_strobes", {gif.rand_st, gif.bst, gif.cst}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_greet", gif.state_o, 1);

    // start dropped in BOK; stray beep_over; held sure
    greet_to_play();
    gif.sw   = 7'd42;
    gif.sure = 1'b1;
    step();
    gif.sure = 1'b0;
    step();
    chk("bok_state", gif.state_o, 6);
    gif.start = 1'b0;
    step();
    chk("drop_idle", gif.state_o, 0);
    chk("drop_time", gif.time_left, 3);
    chk("drop_target", gif.target, 0);
    gif.beep_over = 1'b1;
    step();
    gif.beep_over = 1'b0;
    chk("stray_beep_state", gif.state_o, 0);
    chk("stray_beep_bst", gif.bst, 0);
    gif.start = 1'b1;
    step();
    chk("restart_greet", gif.state_o, 1);
    gif.sure = 1'b1;
    step();
    greet_to_play();
    step();
    step();
    chk("held_sure_state", gif.state_o, 4);
    chk("held_sure_bst", gif.bst, 0);
    gif.sure = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Central sequencer for the three-round number-guessing game.
- Owns the game state machine: idle, greeting, per-round random target fetch, play, answer check, beep feedback, win and lose.
- Drives the start and enable strobes of the random generator, matrix/counter, beeper and segment display. It does not drive their datapaths.
- Sits between the top-level pin inputs (sw7 level, btn0/btn7 debounced levels, sw[6:0]) and those submodules.

Parameters:
- TICK_DIV, 1000000: clk cycles per game-time tick (one second at 1 MHz).
- ROUND_TIME, 30: ticks allowed per round. Range 1..63.
- MAX_ERR, 3: wrong answers allowed per round before loss. Range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  sw7 level. 1 = game powered, 0 = force idle.
- next  in  1  btn7 debounced level. Rising edge begins round 1 from greet.
- sure  in  1  btn0 debounced level. Rising edge submits an answer.
- sw  in  7  player answer
- rand_num  in  7  random generator output
- beep_over  in  1  beeper done pulse (1 cycle)
- rand_st  out  1  1-cycle random request
- cst  out  1  counter/matrix run enable (level)
- dzst  out  1  matrix pattern show enable (level)
- dz_num  out  3  matrix pattern select
- bst  out  1  1-cycle beep start
- beep_mode  out  1  0 = success tone, 1 = error tone
- dst  out  1  segment display enable
- disp_num  out  2  current round, 0..2
- target  out  7  latched target value
- time_left  out  6  remaining ticks in round
- err_cnt  out  3  wrong answers this round
- state_o  out  4  state encoding, for LEDs and debug

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except time_left = ROUND_TIME.
  - The edge-detect history registers for next and sure are cleared.
- Edge detect: next and sure are registered once. A rise means current=1 and previous=0. Holding a button produces exactly one event.
- start=0 in any state: the next state is IDLE, with priority over all other transitions. Round, err_cnt and target clear, and time_left reloads. This takes effect one clk after sampling.
- States (state_o value):
  - IDLE (0): all enables low. start=1 goes to GREET.
  - GREET (1): dzst=1, dz_num=0, dst=1. A next rise goes to REQ with round=0.
  - REQ (2): rand_st=1 for exactly this one cycle, then LATCH.
  - LATCH (3): target is loaded from rand_num. time_left = ROUND_TIME, err_cnt = 0, tick divider cleared. Go to PLAY.
  - PLAY (4):
    - cst=1, dzst=1, dz_num=round+1, dst=1.
    - The divider counts clk cycles. At TICK_DIV-1 it wraps and time_left decrements.
    - If time_left=1 when the tick fires, it becomes 0 and the next state is LOSE.
    - A sure rise goes to CHECK.
    - If a sure rise and the final tick occur in the same cycle, the tick wins and the next state is LOSE.
  - CHECK (5):
    - One cycle. The divider is frozen.
    - sw==target: bst=1, beep_mode=0, next state BOK.
    - Otherwise: err_cnt+1, bst=1, beep_mode=1, next state BERR.
  - BOK (6):
    - Wait for beep_over. The divider and timer are frozen.
    - Then, if round==2, go to WIN. Otherwise round+1 and go to REQ.
  - BERR (7):
    - Wait for beep_over. The divider and timer are frozen.
    - Then, if err_cnt==MAX_ERR, go to LOSE. Otherwise return to PLAY with time_left unchanged.
  - WIN (8): dzst=1, dz_num=4, dst=1, disp_num=2. A next rise goes to GREET.
  - LOSE (9): dzst=1, dz_num=5, dst=1. A next rise goes to GREET.
- bst and rand_st are registered pulses, never longer than 1 cycle.
- beep_mode holds its value until the next bst.
- disp_num = round in every state.
- The tick divider width is clog2(TICK_DIV). It counts only in PLAY and clears in LATCH.
- beep_over arriving in a state other than BOK or BERR is ignored.
- sure and next rises in states that do not use them are discarded, not queued.
- Unused state codes 10..15 go to IDLE.

Test Plan:
Benches use TICK_DIV=4, ROUND_TIME=3, MAX_ERR=2.
1. Reset while in PLAY with time_left=2 -> state_o=0 immediately (asynchronously), time_left=3, all strobes 0.
2. start=1, next rise, rand_num=7'd42 -> exactly one rand_st cycle; target=42 one cycle after REQ; state_o=4, dz_num=1.
3. In round 0 with target=42, set sw=42 and give a sure rise -> bst=1 for 1 cycle with beep_mode=0; after beep_over, state REQ, disp_num=1. Repeating for rounds 1 and 2 -> state_o=8, dz_num=4.
4. sw=41, sure rise twice with beep_over returned each time -> err_cnt 1 then 2, beep_mode=1; state_o=9 after the second beep_over.
5. No sure for 12 cycles in PLAY -> time_left 3→2→1→0 at cycles 4, 8, 12, then state_o=9. A sure rise on the final tick cycle -> LOSE, no bst.
6. start dropped during BOK before beep_over -> state_o=0 next cycle; a later beep_over is ignored; sure held high across GREET→PLAY produces no CHECK.
